// File: rtl/mux4_arb_pkg.sv
// Shared encodings and widths for the 4-way round-robin mux arbiter.
// Holds the FSM state type, index/count widths and a one-hot helper.
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning from ptr upward
// with wrap. idx is only meaningful when any=1.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    idx     = ptr;
    w_found = 1'b0;
    w_cand  = ptr;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = ptr + IDX_W'(i);
      if (!w_found && req[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4-to-1 mux. A grant lasts while its
// request stays up, capped at MAX_HOLD cycles; release re-arbitrates with no gap.
// Handshake: valid=1 means grant/sel name the requester whose mux input is live;
// there is no backpressure, a requester simply holds req until it sees its grant.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] sel,
  output logic             valid,
  output state_t           o_dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_sel, w_sel_nxt;
  logic             r_valid, w_valid_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;

  logic             w_release;
  logic [IDX_W-1:0] w_pick_ptr;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;

  // Drop of the held request and hold expiry collapse into one release event,
  // so the pointer advances exactly once.
  assign w_release  = (r_state == ST_GRANT) && (!req[r_sel] || (r_count == HOLD_LAST));
  assign w_pick_ptr = w_release ? r_sel + 2'd1 : r_ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = onehot4(w_pick_idx);
          w_sel_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_count_nxt = '0;
        end else begin
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_pick_ptr;
          if (w_pick_any) begin
            w_grant_nxt = onehot4(w_pick_idx);
            w_sel_nxt   = w_pick_idx;
            w_valid_nxt = 1'b1;
            w_count_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_count_nxt = '0;
          end
        end else begin
          w_count_nxt = r_count + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign grant       = r_grant;
  assign sel         = r_sel;
  assign valid       = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (MAX_HOLD 4, 2, 1) fed directed
// vectors with hand-computed responses, plus a random run with property checks.
module tb_mux4_rr_arbiter;
  import mux4_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req4 = '0, req2 = '0, req1 = '0;
  logic [3:0] grant4, grant2, grant1;
  logic [1:0] sel4, sel2, sel1;
  logic       valid4, valid2, valid1;
  state_t     st4, st2, st1;

  // Mux data inputs IN0..IN3 = 1,0,1,0.
  logic [3:0] mux_in = 4'b0101;

  // Entry: {check_mux, mux, valid, sel[1:0], grant[3:0]}
  logic [8:0] q4[$];
  logic [8:0] q2[$];
  logic [8:0] q1[$];

  int checks = 0;
  int errors = 0;
  bit rnd_on = 1'b0;
  int run_len = 0;
  logic [3:0] prev_g = '0;
  int wait_cnt[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .grant(grant4), .sel(sel4),
    .valid(valid4), .o_dbg_state(st4));
  mux4_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .grant(grant2), .sel(sel2),
    .valid(valid2), .o_dbg_state(st2));
  mux4_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .grant(grant1), .sel(sel1),
    .valid(valid1), .o_dbg_state(st1));

  task automatic step(input int d, input logic rst, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] s, input logic v,
                      input int m = -1);
    logic [8:0] e;
    e = {(m >= 0), (m == 1), v, s, g};
    @(negedge clk);
    reset = rst;
    case (d)
      4:       begin req4 = r; q4.push_back(e); end
      2:       begin req2 = r; q2.push_back(e); end
      default: begin req1 = r; q1.push_back(e); end
    endcase
  endtask

  task automatic cmp(input string name, input logic [8:0] e, input logic [3:0] g,
                     input logic [1:0] s, input logic v);
    logic mo;
    mo = mux_in[s];
    checks++;
    if (g !== e[3:0] || s !== e[5:4] || v !== e[6] || (e[8] && mo !== e[7])) begin
      errors++;
      $display("FAIL %s: got grant=%b sel=%b valid=%b mux=%b, want grant=%b sel=%b valid=%b mux=%b",
               name, g, s, v, mo, e[3:0], e[5:4], e[6], e[7]);
    end
  endtask

  // Monitor: one response per clock per instance, sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) cmp("dut4", q4.pop_front(), grant4, sel4, valid4);
    if (q2.size() > 0) cmp("dut2", q2.pop_front(), grant2, sel2, valid2);
    if (q1.size() > 0) cmp("dut1", q1.pop_front(), grant1, sel1, valid1);
    if (rnd_on) begin
      checks++;
      if (!((!valid2 && grant2 == 4'b0000) ||
            (valid2 && $onehot(grant2) && grant2 == (4'b0001 << sel2)))) begin
        errors++;
        $display("FAIL rnd_shape: got grant=%b sel=%b valid=%b, want one-hot grant matching sel",
                 grant2, sel2, valid2);
      end
      if (valid2 && grant2 == prev_g) run_len++;
      else run_len = valid2 ? 1 : 0;
      if (run_len > 2) begin
        checks++;
        if ((req2 & ~grant2) != 4'b0000) begin
          errors++;
          $display("FAIL rnd_hold: got run=%0d with req=%b, want at most 2", run_len, req2);
        end
        run_len = 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (req2[i] && !grant2[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
      end
      checks++;
      if (wait_cnt[0] > 8 || wait_cnt[1] > 8 || wait_cnt[2] > 8 || wait_cnt[3] > 8) begin
        errors++;
        $display("FAIL rnd_starve: got waits=%0d,%0d,%0d,%0d, want each <= 8",
                 wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
      end
      prev_g = grant2;
    end
  end

  initial begin
    logic [3:0] r;
    // MAX_HOLD=4: reset, idle hold, sole requester.
    step(4, 1, 4'b0000, 4'b0000, 2'b00, 0);
    for (int i = 0; i < 5; i++) step(4, 0, 4'b0000, 4'b0000, 2'b00, 0);
    for (int i = 0; i < 9; i++) step(4, 0, 4'b0100, 4'b0100, 2'b10, 1);
    // Grant on 3, then pointer wraps to 0.
    step(4, 0, 4'b1000, 4'b1000, 2'b11, 1);
    step(4, 0, 4'b0001, 4'b0001, 2'b00, 1);
    step(4, 0, 4'b0000, 4'b0000, 2'b00, 0);
    step(4, 0, 4'b0000, 4'b0000, 2'b00, 0);
    // Drop and expiry together: single pointer advance selects 2, not 3.
    for (int i = 0; i < 4; i++) step(4, 0, 4'b0010, 4'b0010, 2'b01, 1);
    step(4, 0, 4'b1100, 4'b0100, 2'b10, 1);
    step(4, 0, 4'b0000, 4'b0000, 2'b10, 0);
    step(4, 0, 4'b0000, 4'b0000, 2'b10, 0);
    // Other requesters toggling do not disturb the active grant.
    step(4, 0, 4'b0001, 4'b0001, 2'b00, 1);
    step(4, 0, 4'b0111, 4'b0001, 2'b00, 1);
    step(4, 0, 4'b1011, 4'b0001, 2'b00, 1);
    step(4, 0, 4'b0001, 4'b0001, 2'b00, 1);
    step(4, 0, 4'b0110, 4'b0010, 2'b01, 1);
    step(4, 0, 4'b0000, 4'b0000, 2'b01, 0);

    // MAX_HOLD=2: full rotation with mux output.
    step(2, 1, 4'b0000, 4'b0000, 2'b00, 0);
    step(2, 0, 4'b1111, 4'b0001, 2'b00, 1, 1);
    step(2, 0, 4'b1111, 4'b0001, 2'b00, 1, 1);
    step(2, 0, 4'b1111, 4'b0010, 2'b01, 1, 0);
    step(2, 0, 4'b1111, 4'b0010, 2'b01, 1, 0);
    step(2, 0, 4'b1111, 4'b0100, 2'b10, 1, 1);
    step(2, 0, 4'b1111, 4'b0100, 2'b10, 1, 1);
    step(2, 0, 4'b1111, 4'b1000, 2'b11, 1, 0);
    step(2, 0, 4'b1111, 4'b1000, 2'b11, 1, 0);
    step(2, 0, 4'b1111, 4'b0001, 2'b00, 1, 1);
    step(2, 0, 4'b1111, 4'b0001, 2'b00, 1, 1);
    // Reset mid-grant on requester 2, then restart from pointer 0.
    step(2, 0, 4'b1111, 4'b0010, 2'b01, 1);
    step(2, 0, 4'b1111, 4'b0010, 2'b01, 1);
    step(2, 0, 4'b1111, 4'b0100, 2'b10, 1);
    step(2, 1, 4'b1111, 4'b0000, 2'b00, 0);
    step(2, 0, 4'b1111, 4'b0001, 2'b00, 1);
    step(2, 0, 4'b1111, 4'b0001, 2'b00, 1);
    step(2, 0, 4'b0000, 4'b0000, 2'b00, 0);

    // MAX_HOLD=1: rotate every cycle.
    step(1, 1, 4'b0000, 4'b0000, 2'b00, 0);
    step(1, 0, 4'b1011, 4'b0001, 2'b00, 1);
    step(1, 0, 4'b1011, 4'b0010, 2'b01, 1);
    step(1, 0, 4'b1011, 4'b1000, 2'b11, 1);
    step(1, 0, 4'b1011, 4'b0001, 2'b00, 1);
    step(1, 0, 4'b1011, 4'b0010, 2'b01, 1);
    step(1, 0, 4'b0100, 4'b0100, 2'b10, 1);
    step(1, 0, 4'b0100, 4'b0100, 2'b10, 1);
    step(1, 0, 4'b0000, 4'b0000, 2'b10, 0);

    // Random sticky requests on the MAX_HOLD=2 instance.
    step(2, 1, 4'b0000, 4'b0000, 2'b00, 0);
    @(negedge clk);
    reset = 1'b0;
    rnd_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = req2 ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      req2 = r;
      @(negedge clk);
    end
    rnd_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per requester (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, request per requester; bit i maps to mux data input INi.
REQ-005 The block SHALL have port grant, output, 4, registered one-hot grant; all zero when idle.
REQ-006 The block SHALL have port sel, output, 2, registered mux select; sel[1] drives s1 and sel[0] drives s0 of the 4-to-1 mux.
REQ-007 The block SHALL have port valid, output, 1, high while any grant is active; mux output is meaningful only when valid=1.

Function
REQ-008 The block SHALL implement a two-state machine: IDLE and GRANT.
REQ-009 Arbitration SHALL be round-robin from a 2-bit priority pointer ptr: the winner is the first set req bit at index ptr, ptr+1, ... mod 4.
REQ-010 In IDLE with req != 0, the block SHALL enter GRANT at the next edge with grant=onehot(winner), sel=winner, valid=1, and hold count=0; latency from req to grant is exactly 1 cycle.
REQ-011 In IDLE with req == 0, the block SHALL remain in IDLE with grant=0 and valid=0; sel SHALL hold its last value.
REQ-012 In GRANT with granted index g, the block SHALL keep the grant and increment count while req[g]=1 and count < MAX_HOLD-1.
REQ-013 Release SHALL occur when req[g]=0 or count == MAX_HOLD-1 (either or both, same handling).
REQ-014 On release, ptr SHALL become (g+1) mod 4, wrapping 3->0.
REQ-015 On release with any req bit set, the block SHALL arbitrate using the updated ptr in the same cycle and issue the new grant at the next edge with no idle gap; g itself may win again if it is the only requester.
REQ-016 On release with req == 0, the block SHALL return to IDLE at the next edge (grant=0, valid=0).
REQ-017 With MAX_HOLD=1, the grant SHALL rotate every cycle among active requesters.
REQ-018 grant SHALL never have more than one bit set, and sel SHALL always equal the index of the set grant bit when valid=1.
REQ-019 Requests changing on non-granted bits SHALL NOT affect an active grant.
REQ-020 count SHALL be 4 bits and SHALL NOT wrap within a grant.

Reset
REQ-021 While reset=1 at a rising edge, the block SHALL set state=IDLE, grant=0000, sel=00, valid=0, ptr=0, and count=0, regardless of the current state or req.
REQ-022 Reset asserted mid-grant SHALL drop the grant at that edge; the first post-reset grant SHALL use ptr=0.

Structure
REQ-023 Shared package mux4_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1), the index width constant (2), and the count width constant (4).
REQ-024 Combinational winner selection SHALL be a sub-module rr_pick4 with inputs req[3:0] and ptr[1:0] and outputs idx[1:0] and any.
REQ-025 All outputs SHALL be driven directly from registers.

Verification
REQ-026 Reset, then req=0000 for 5 cycles -> grant=0000, valid=0, sel=00 throughout.
REQ-027 req=0100 held, MAX_HOLD=4 -> after 1 cycle grant=0100 and sel=10 for 4 cycles, then regrant 0100 with no gap (sole requester).
REQ-028 req=1111 held, MAX_HOLD=2 -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001,... with sel tracking 00,01,10,11; the mux with IN0..IN3=1,0,1,0 outputs 1,1,0,0,1,1,0,0.
REQ-029 Grant on requester 3, then req becomes 0001 -> next grant 0001 (ptr wraps 3->0); req drop and count expiry in the same cycle -> single release, no double pointer advance.
REQ-030 Reset pulsed mid-grant on requester 2 with req=1111 -> grant=0000 at the reset edge, then first grant 0001.
REQ-031 Random req for 1000 cycles -> grant one-hot or zero, sel matches grant, no grant run exceeds MAX_HOLD, and every held request is granted within 4*MAX_HOLD cycles.
